// File: rtl/sar_search_ctrl_pkg.sv
// rtl/sar_search_ctrl_pkg.sv - shared types and constants for the SAR search controller
package sar_search_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_ZERO  = 2'd2,
        ST_DONE  = 2'd3
    } sar_state_t;

    // Flag vector order is {lower, equal, greater}.
    localparam logic [2:0] FLAG_LOWER   = 3'b100;
    localparam logic [2:0] FLAG_EQUAL   = 3'b010;
    localparam logic [2:0] FLAG_GREATER = 3'b001;

    localparam int DEFAULT_W       = 16;
    localparam int DEFAULT_TIMEOUT = 255;

    function automatic logic flags_onehot(input logic [2:0] f);
        return (f == FLAG_LOWER) || (f == FLAG_EQUAL) || (f == FLAG_GREATER);
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - successive-approximation search initiator for the magnitude-compare path
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         abort_i,
    output logic [W-1:0] probe_o,
    output logic         probe_valid_o,
    input  logic         cmp_valid_i,
    input  logic         cmp_lower_i,
    input  logic         cmp_equal_i,
    input  logic         cmp_greater_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         found_o,
    output logic         none_o,
    output logic         err_o
);

    localparam int IW = $clog2(W);
    localparam int CW = $clog2(TIMEOUT + 1);

    sar_state_t     state_q;
    logic [W-1:0]   acc_q, probe_q, result_q;
    logic [IW-1:0]  idx_q;
    logic [CW-1:0]  wait_q;
    logic           probe_valid_q, busy_q, done_q, found_q, none_q, err_q;

    logic [2:0]     flags;
    logic [W-1:0]   bit_w, acc_d;

    assign flags = {cmp_lower_i, cmp_equal_i, cmp_greater_i};
    assign bit_w = {{(W-1){1'b0}}, 1'b1} << idx_q;
    // A lower or equal response means this probe still satisfies f(probe) <= threshold.
    assign acc_d = (cmp_lower_i || cmp_equal_i) ? (acc_q | bit_w) : acc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            idx_q         <= IW'(W - 1);
            wait_q        <= '0;
            probe_q       <= '0;
            probe_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            found_q       <= 1'b0;
            none_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && state_q != ST_IDLE) begin
                state_q       <= ST_IDLE;
                probe_valid_q <= 1'b0;
                busy_q        <= 1'b0;
                wait_q        <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            acc_q         <= '0;
                            found_q       <= 1'b0;
                            none_q        <= 1'b0;
                            err_q         <= 1'b0;
                            idx_q         <= IW'(W - 1);
                            wait_q        <= '0;
                            probe_q       <= {1'b1, {(W-1){1'b0}}};
                            probe_valid_q <= 1'b1;
                            busy_q        <= 1'b1;
                            state_q       <= ST_PROBE;
                        end
                    end
                    ST_PROBE, ST_ZERO: begin
                        if (cmp_valid_i) begin
                            wait_q <= '0;
                            if (!flags_onehot(flags)) begin
                                err_q         <= 1'b1;
                                probe_valid_q <= 1'b0;
                                state_q       <= ST_DONE;
                            end else if (state_q == ST_ZERO) begin
                                found_q       <= cmp_equal_i;
                                none_q        <= cmp_greater_i;
                                probe_valid_q <= 1'b0;
                                state_q       <= ST_DONE;
                            end else if (cmp_equal_i) begin
                                acc_q         <= acc_d;
                                found_q       <= 1'b1;
                                probe_valid_q <= 1'b0;
                                state_q       <= ST_DONE;
                            end else begin
                                acc_q <= acc_d;
                                if (idx_q == '0) begin
                                    if (acc_d == '0) begin
                                        probe_q <= '0;
                                        state_q <= ST_ZERO;
                                    end else begin
                                        probe_valid_q <= 1'b0;
                                        state_q       <= ST_DONE;
                                    end
                                end else begin
                                    idx_q   <= idx_q - 1'b1;
                                    probe_q <= acc_d | (bit_w >> 1);
                                end
                            end
                        end else if (wait_q == CW'(TIMEOUT - 1)) begin
                            err_q         <= 1'b1;
                            probe_valid_q <= 1'b0;
                            state_q       <= ST_DONE;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        done_q   <= 1'b1;
                        result_q <= acc_q;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign probe_o       = probe_q;
    assign probe_valid_o = probe_valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign found_o       = found_q;
    assign none_o        = none_q;
    assign err_o         = err_q;

endmodule
